// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the instruction-decode stage: field positions,
// supported opcode/funct sets and the ID/EX field bundle.
`default_nettype none

package id_stage_pkg;

   localparam int SIZE_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int REG_AW    = 5;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;
   localparam int RS_MSB  = 25;
   localparam int RS_LSB  = 21;
   localparam int RT_MSB  = 20;
   localparam int RT_LSB  = 16;
   localparam int RD_MSB  = 15;
   localparam int RD_LSB  = 11;
   localparam int SH_MSB  = 10;
   localparam int SH_LSB  = 6;
   localparam int FN_MSB  = 5;
   localparam int FN_LSB  = 0;
   localparam int IMM_MSB = 15;
   localparam int IMM_W   = 16;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00,
      OP_J     = 6'h02,
      OP_JAL   = 6'h03,
      OP_BEQ   = 6'h04,
      OP_BNE   = 6'h05,
      OP_ADDI  = 6'h08,
      OP_ADDIU = 6'h09,
      OP_SLTI  = 6'h0A,
      OP_SLTIU = 6'h0B,
      OP_ANDI  = 6'h0C,
      OP_ORI   = 6'h0D,
      OP_XORI  = 6'h0E,
      OP_LUI   = 6'h0F,
      OP_LW    = 6'h23,
      OP_SW    = 6'h2B
   } opcode_e;

   typedef enum logic [5:0] {
      FN_SLL  = 6'h00,
      FN_SRL  = 6'h02,
      FN_SRA  = 6'h03,
      FN_JR   = 6'h08,
      FN_MFHI = 6'h10,
      FN_MFLO = 6'h12,
      FN_MULT = 6'h18,
      FN_DIV  = 6'h1A,
      FN_ADD  = 6'h20,
      FN_ADDU = 6'h21,
      FN_SUB  = 6'h22,
      FN_SUBU = 6'h23,
      FN_AND  = 6'h24,
      FN_OR   = 6'h25,
      FN_XOR  = 6'h26,
      FN_NOR  = 6'h27,
      FN_SLT  = 6'h2A,
      FN_SLTU = 6'h2B
   } funct_e;

   typedef struct packed {
      logic [5:0] opcode;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [4:0] shamt;
      logic [5:0] funct;
      logic       valid;
      logic       illegal;
   } id_fields_t;

   function automatic logic opcode_supported(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
         OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
         OP_LW, OP_SW:  return 1'b1;
         default:       return 1'b0;
      endcase
   endfunction

   function automatic logic funct_supported(input logic [5:0] fn);
      case (fn)
         FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_MFHI, FN_MFLO, FN_MULT, FN_DIV,
         FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
         FN_SLT, FN_SLTU:  return 1'b1;
         default:          return 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/id_regfile.sv
// Register file: two combinational read ports with write-through bypass, one
// synchronous write port; r0 is hardwired to zero.
`default_nettype none

module id_regfile
   import id_stage_pkg::*;
#(
   parameter int SIZE  = SIZE_DEF,
   parameter int NREGS = NREGS_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [SIZE-1:0]   wdata_i,
   input  logic [REG_AW-1:0] raddr_a_i,
   output logic [SIZE-1:0]   rdata_a_o,
   input  logic [REG_AW-1:0] raddr_b_i,
   output logic [SIZE-1:0]   rdata_b_o
);

   logic [SIZE-1:0] mem_q [NREGS];
   logic            wr_en;

   assign wr_en = we_i && (waddr_i != '0) && (int'(waddr_i) < NREGS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Bypass makes a write-back in the same cycle visible to the decoding instruction.
   always_comb begin
      rdata_a_o = '0;
      if (raddr_a_i == '0 || int'(raddr_a_i) >= NREGS) begin
         rdata_a_o = '0;
      end else if (wr_en && waddr_i == raddr_a_i) begin
         rdata_a_o = wdata_i;
      end else begin
         rdata_a_o = mem_q[raddr_a_i];
      end
   end

   always_comb begin
      rdata_b_o = '0;
      if (raddr_b_i == '0 || int'(raddr_b_i) >= NREGS) begin
         rdata_b_o = '0;
      end else if (wr_en && waddr_i == raddr_b_i) begin
         rdata_b_o = wdata_i;
      end else begin
         rdata_b_o = mem_q[raddr_b_i];
      end
   end

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// Instruction decode stage: field split, register read, legality check and the
// ID/EX pipeline register with flush > stall > load priority.
`default_nettype none

module id_stage
   import id_stage_pkg::*;
#(
   parameter int SIZE  = SIZE_DEF,
   parameter int NREGS = NREGS_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SIZE-1:0]   IF_ID,
   input  logic              if_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [SIZE-1:0]   wb_data,
   output logic [SIZE-1:0]   ID_EX_rs_data,
   output logic [SIZE-1:0]   ID_EX_rt_data,
   output logic [SIZE-1:0]   ID_EX_imm,
   output logic [4:0]        ID_EX_rs,
   output logic [4:0]        ID_EX_rt,
   output logic [4:0]        ID_EX_rd,
   output logic [4:0]        ID_EX_shamt,
   output logic [5:0]        ID_EX_opcode,
   output logic [5:0]        ID_EX_funct,
   output logic              ID_EX_valid,
   output logic              ID_EX_illegal
);

   id_fields_t      dec_fields;
   logic [SIZE-1:0] dec_imm;
   logic [SIZE-1:0] rs_rdata;
   logic [SIZE-1:0] rt_rdata;
   logic            dec_illegal;

   id_fields_t      fields_q,  fields_d;
   logic [SIZE-1:0] rs_data_q, rs_data_d;
   logic [SIZE-1:0] rt_data_q, rt_data_d;
   logic [SIZE-1:0] imm_q,     imm_d;

   id_regfile #(
      .SIZE  (SIZE),
      .NREGS (NREGS)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (wb_we),
      .waddr_i   (wb_addr),
      .wdata_i   (wb_data),
      .raddr_a_i (IF_ID[RS_MSB:RS_LSB]),
      .rdata_a_o (rs_rdata),
      .raddr_b_i (IF_ID[RT_MSB:RT_LSB]),
      .rdata_b_o (rt_rdata)
   );

   assign dec_illegal = !opcode_supported(IF_ID[OPC_MSB:OPC_LSB]) ||
                        ((IF_ID[OPC_MSB:OPC_LSB] == OP_RTYPE) &&
                         !funct_supported(IF_ID[FN_MSB:FN_LSB]));

   always_comb begin
      dec_fields         = '0;
      dec_fields.opcode  = IF_ID[OPC_MSB:OPC_LSB];
      dec_fields.rs      = IF_ID[RS_MSB:RS_LSB];
      dec_fields.rt      = IF_ID[RT_MSB:RT_LSB];
      dec_fields.rd      = IF_ID[RD_MSB:RD_LSB];
      dec_fields.shamt   = IF_ID[SH_MSB:SH_LSB];
      dec_fields.funct   = IF_ID[FN_MSB:FN_LSB];
      dec_fields.valid   = 1'b1;
      dec_fields.illegal = dec_illegal;
   end

   assign dec_imm = {{(SIZE-IMM_W){IF_ID[IMM_MSB]}}, IF_ID[IMM_MSB:0]};

   // A bubble (flush, or no valid instruction while not stalled) clears every field.
   always_comb begin
      fields_d  = fields_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      if (flush) begin
         fields_d  = '0;
         rs_data_d = '0;
         rt_data_d = '0;
         imm_d     = '0;
      end else if (!stall) begin
         if (if_valid) begin
            fields_d  = dec_fields;
            rs_data_d = rs_rdata;
            rt_data_d = rt_rdata;
            imm_d     = dec_imm;
         end else begin
            fields_d  = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fields_q  <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
      end else begin
         fields_q  <= fields_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
      end
   end

   assign ID_EX_rs_data = rs_data_q;
   assign ID_EX_rt_data = rt_data_q;
   assign ID_EX_imm     = imm_q;
   assign ID_EX_rs      = fields_q.rs;
   assign ID_EX_rt      = fields_q.rt;
   assign ID_EX_rd      = fields_q.rd;
   assign ID_EX_shamt   = fields_q.shamt;
   assign ID_EX_opcode  = fields_q.opcode;
   assign ID_EX_funct   = fields_q.funct;
   assign ID_EX_valid   = fields_q.valid;
   assign ID_EX_illegal = fields_q.illegal;

endmodule

`default_nettype wire
